// File: rtl/logic_gate_pkg.sv
// Shared gate function codes and checker FSM state encoding.
package logic_gate_pkg;

  localparam int unsigned SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    G_AND  = 3'd0,
    G_OR   = 3'd1,
    G_XOR  = 3'd2,
    G_NAND = 3'd3,
    G_NOR  = 3'd4,
    G_XNOR = 3'd5,
    G_NOTA = 3'd6,
    G_BUFA = 3'd7
  } gate_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/logic_gate_checker_gate_ref_model.sv
// Combinational golden model: expected gate output for the selected function.
module gate_ref_model
  import logic_gate_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             a,
  input  logic             b,
  output logic             y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (gate_e'(sel))
      G_AND:   y_exp = a & b;
      G_OR:    y_exp = a | b;
      G_XOR:   y_exp = a ^ b;
      G_NAND:  y_exp = ~(a & b);
      G_NOR:   y_exp = ~(a | b);
      G_XNOR:  y_exp = ~(a ^ b);
      G_NOTA:  y_exp = ~a;
      G_BUFA:  y_exp = a;
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_checker.sv
// Runs a fixed-length check of an external gate against the reference model,
// accumulating error count, input coverage and the first failing vector.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int unsigned VEC_TARGET = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] gate_sel,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic [1:0]       first_err,
  output logic             first_err_vld
);

  // Run-length counter must reach VEC_TARGET even when CNT_W is narrower.
  localparam int unsigned TGT_W = $clog2(VEC_TARGET + 1);
  localparam int unsigned ACC_W = (TGT_W > CNT_W) ? TGT_W : CNT_W;

  state_e             state, state_nxt;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   err_nxt;
  logic [3:0]         cov_nxt;
  logic [1:0]         fe_nxt;
  logic               fev_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic               y_exp;

  gate_ref_model u_ref (
    .sel   (sel_q),
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  assign vec_count = acc[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel_q         <= '0;
      acc           <= '0;
      err_count     <= '0;
      coverage      <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state         <= state_nxt;
      sel_q         <= sel_nxt;
      acc           <= acc_nxt;
      err_count     <= err_nxt;
      coverage      <= cov_nxt;
      first_err     <= fe_nxt;
      first_err_vld <= fev_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    acc_nxt   = acc;
    err_nxt   = err_count;
    cov_nxt   = coverage;
    fe_nxt    = first_err;
    fev_nxt   = first_err_vld;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_CHECK;
          sel_nxt   = gate_sel;
          acc_nxt   = '0;
          err_nxt   = '0;
          cov_nxt   = '0;
          fe_nxt    = '0;
          fev_nxt   = 1'b0;
        end
      end
      ST_CHECK: begin
        if (valid) begin
          acc_nxt = ACC_W'(acc + ACC_W'(1));
          cov_nxt[{a, b}] = 1'b1;
          if (y != y_exp) begin
            if (err_count != '1) err_nxt = CNT_W'(err_count + CNT_W'(1));
            if (!first_err_vld) begin
              fe_nxt  = {a, b};
              fev_nxt = 1'b1;
            end
          end
          if (acc_nxt == ACC_W'(VEC_TARGET)) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Status flags are registered from the next state so they align with it.
    busy_nxt = (state_nxt == ST_CHECK);
    done_nxt = (state_nxt == ST_DONE);
    pass_nxt = done_nxt && (err_nxt == '0) && (cov_nxt == 4'hF);
  end

endmodule
